// File: rtl/acc_phase_sequencer.sv
// acc_phase_sequencer
// Sequences the accelerator's load / run / send phases from one command word.
// Each selected phase gets a one-cycle request pulse, followed by a wait for
// its synchronized done pulse. Every wait is guarded by a timeout counter.
// An abort input ends the active command early.
`timescale 1ns/1ps

module acc_phase_sequencer #(
  parameter int unsigned          TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = TIMEOUT_W'(24'hFF_FFFF),
  parameter int unsigned          CNT_W     = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_ops,
  input  logic             abort,
  output logic             acc_load_kdtree,
  input  logic             acc_load_done,
  output logic             acc_fsm_start,
  input  logic             acc_fsm_done,
  output logic             acc_send_best_arr,
  input  logic             acc_send_done,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [1:0]       err_phase,
  output logic [CNT_W-1:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REQ,
    S_LOAD_WAIT,
    S_RUN_REQ,
    S_RUN_WAIT,
    S_SEND_REQ,
    S_SEND_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_ABORT   = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_LOAD = 2'd1,
    PH_RUN  = 2'd2,
    PH_SEND = 2'd3
  } phase_e;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT - TIMEOUT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       ops_q, ops_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  err_e             err_code_q, err_code_d;
  phase_e           err_phase_q, err_phase_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;

  phase_e           phase_cur;
  logic             tmo_hit;
  state_e           first_req;
  state_e           after_load;
  state_e           after_run;

  // Phase owning the current state; REQ states count as their own phase.
  always_comb begin
    phase_cur = PH_NONE;
    case (state_q)
      S_LOAD_REQ, S_LOAD_WAIT: phase_cur = PH_LOAD;
      S_RUN_REQ,  S_RUN_WAIT:  phase_cur = PH_RUN;
      S_SEND_REQ, S_SEND_WAIT: phase_cur = PH_SEND;
      default:                 phase_cur = PH_NONE;
    endcase
  end

  // Successor selection: lowest remaining op bit, or DONE when none remain.
  always_comb begin
    if (cmd_ops[0])      first_req = S_LOAD_REQ;
    else if (cmd_ops[1]) first_req = S_RUN_REQ;
    else if (cmd_ops[2]) first_req = S_SEND_REQ;
    else                 first_req = S_DONE;

    if (ops_q[1])        after_load = S_RUN_REQ;
    else if (ops_q[2])   after_load = S_SEND_REQ;
    else                 after_load = S_DONE;

    if (ops_q[2])        after_run = S_SEND_REQ;
    else                 after_run = S_DONE;
  end

  // Last permitted wait cycle reached; a zero TIMEOUT never expires.
  always_comb begin
    tmo_hit = (TIMEOUT != '0) && (tmo_q == TMO_LAST);
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, with the error status that each exit records.
  // A done pulse is checked before the timeout, so both in one cycle complete
  // normally. The abort override comes last, so it wins over both.
  always_comb begin
    state_d     = state_q;
    ops_d       = ops_q;
    err_code_d  = err_code_q;
    err_phase_d = err_phase_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ops_d       = cmd_ops;
          err_code_d  = ERR_OK;
          err_phase_d = PH_NONE;
          state_d     = first_req;
        end
      end
      S_LOAD_REQ:  state_d = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        if (acc_load_done) begin
          state_d = after_load;
        end else if (tmo_hit) begin
          state_d     = S_DONE;
          err_code_d  = ERR_TIMEOUT;
          err_phase_d = PH_LOAD;
        end
      end
      S_RUN_REQ:   state_d = S_RUN_WAIT;
      S_RUN_WAIT: begin
        if (acc_fsm_done) begin
          state_d = after_run;
        end else if (tmo_hit) begin
          state_d     = S_DONE;
          err_code_d  = ERR_TIMEOUT;
          err_phase_d = PH_RUN;
        end
      end
      S_SEND_REQ:  state_d = S_SEND_WAIT;
      S_SEND_WAIT: begin
        if (acc_send_done) begin
          state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d     = S_DONE;
          err_code_d  = ERR_TIMEOUT;
          err_phase_d = PH_SEND;
        end
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d     = S_DONE;
      err_code_d  = ERR_ABORT;
      err_phase_d = phase_cur;
    end
  end

  // Counter next values: timeout restarts in each REQ cycle so that the
  // following WAIT begins at zero; run_cycles saturates instead of wrapping.
  always_comb begin
    tmo_d        = tmo_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) run_cycles_d = '0;
      end
      S_LOAD_REQ, S_RUN_REQ, S_SEND_REQ: begin
        tmo_d = '0;
      end
      S_LOAD_WAIT, S_SEND_WAIT: begin
        tmo_d = tmo_q + TIMEOUT_W'(1);
      end
      S_RUN_WAIT: begin
        tmo_d = tmo_q + TIMEOUT_W'(1);
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + CNT_W'(1);
      end
      default: begin
        tmo_d = tmo_q;
      end
    endcase
  end

  // Datapath registers: latched ops, timeout counter and result status.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ops_q        <= '0;
      tmo_q        <= '0;
      err_code_q   <= ERR_OK;
      err_phase_q  <= PH_NONE;
      run_cycles_q <= '0;
    end else begin
      ops_q        <= ops_d;
      tmo_q        <= tmo_d;
      err_code_q   <= err_code_d;
      err_phase_q  <= err_phase_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Outputs decoded from the registered state only, so no input reaches an
  // output combinationally and the request pulses are mutually exclusive.
  always_comb begin
    cmd_ready         = (state_q == S_IDLE);
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_DONE);
    acc_load_kdtree   = (state_q == S_LOAD_REQ);
    acc_fsm_start     = (state_q == S_RUN_REQ);
    acc_send_best_arr = (state_q == S_SEND_REQ);
    err_code          = err_code_q;
    err_phase         = err_phase_q;
    run_cycles        = run_cycles_q;
  end

endmodule

// File: tb/tb_acc_phase_sequencer.sv
// Testbench for acc_phase_sequencer: random and directed commands.
// A reactive responder returns done pulses, and a scoreboard checks each
// termination against a timeline model.
`timescale 1ns/1ps

module tb_acc_phase_sequencer;

  localparam int T     = 16;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, abort;
  logic [2:0]  cmd_ops;
  logic        load_req, fsm_req, send_req;
  logic        load_done, fsm_done, send_done;
  logic        busy, done;
  logic [1:0]  err_code, err_phase;
  logic [31:0] run_cycles;

  // Second instance: timeout disabled, narrow saturating run counter.
  logic        r2_valid, r2_ready, r2_fsm_done;
  logic [2:0]  r2_ops;
  logic        r2_load_req, r2_fsm_req, r2_send_req, r2_busy, r2_done;
  logic [1:0]  r2_code, r2_phase;
  logic [2:0]  r2_run;

  always #5 clk = ~clk;

  acc_phase_sequencer #(.TIMEOUT_W(24), .TIMEOUT(24'd16), .CNT_W(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ops(cmd_ops), .abort(abort),
    .acc_load_kdtree(load_req), .acc_load_done(load_done),
    .acc_fsm_start(fsm_req), .acc_fsm_done(fsm_done),
    .acc_send_best_arr(send_req), .acc_send_done(send_done),
    .busy(busy), .done(done), .err_code(err_code), .err_phase(err_phase),
    .run_cycles(run_cycles)
  );

  acc_phase_sequencer #(.TIMEOUT_W(24), .TIMEOUT(24'd0), .CNT_W(3)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(r2_valid), .cmd_ready(r2_ready),
    .cmd_ops(r2_ops), .abort(1'b0),
    .acc_load_kdtree(r2_load_req), .acc_load_done(1'b0),
    .acc_fsm_start(r2_fsm_req), .acc_fsm_done(r2_fsm_done),
    .acc_send_best_arr(r2_send_req), .acc_send_done(1'b0),
    .busy(r2_busy), .done(r2_done), .err_code(r2_code), .err_phase(r2_phase),
    .run_cycles(r2_run)
  );

  typedef struct {
    int         done_cyc;
    logic [1:0] code;
    logic [1:0] phase;
    int         run;
    logic [5:0] seq;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         dly[3];
  int         cnt[3];
  logic [2:0] stray;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit pending();
    return (cnt[0] != 0) || (cnt[1] != 0) || (cnt[2] != 0);
  endfunction

  // Timeline model: phases run in bit order; a phase requested at cycle r
  // waits from r+1, ends at r+d on its done, or at r+T if d exceeds T.
  // An abort inside [r, end] wins; run_cycles counts wait cycles up to exit.
  function automatic exp_t model(input logic [2:0] ops, input int d0, input int d1,
                                 input int d2, input int ab, input int acc);
    exp_t e;
    int   dd[3];
    int   t;
    int   r;
    int   fin;
    bit   timed;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    e.code = 2'd0; e.phase = 2'd0; e.run = 0; e.seq = 6'd0;
    t = 1;
    for (int p = 0; p < 3; p++) begin
      if (ops[p]) begin
        r = t;
        e.seq = {e.seq[3:0], 2'(p + 1)};
        if (ab == r) begin
          e.code = 2'd2; e.phase = 2'(p + 1); e.done_cyc = acc + r + 1;
          return e;
        end
        timed = (dd[p] > T);
        fin   = timed ? r + T : r + dd[p];
        if (ab > r && ab <= fin) begin
          e.code = 2'd2; e.phase = 2'(p + 1);
          if (p == 1) e.run = ab - r;
          e.done_cyc = acc + ab + 1;
          return e;
        end
        if (p == 1) e.run = fin - r;
        if (timed) begin
          e.code = 2'd1; e.phase = 2'(p + 1); e.done_cyc = acc + fin + 1;
          return e;
        end
        t = fin + 1;
      end
    end
    e.done_cyc = acc + t;
    return e;
  endfunction

  // Responder: turns each request into a done pulse dly[p] cycles later,
  // ORed with any stray pulses the stimulus asks for.
  initial begin
    logic [2:0] fire;
    load_done = 1'b0; fsm_done = 1'b0; send_done = 1'b0;
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    forever begin
      @(negedge clk);
      #1;
      fire = 3'b000;
      if (rst) begin
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
      end else begin
        for (int p = 0; p < 3; p++) begin
          if (cnt[p] > 0) begin
            cnt[p]--;
            if (cnt[p] == 0) fire[p] = 1'b1;
          end
        end
        if (load_req && dly[0] < NEVER) cnt[0] = dly[0];
        if (fsm_req  && dly[1] < NEVER) cnt[1] = dly[1];
        if (send_req && dly[2] < NEVER) cnt[2] = dly[2];
      end
      load_done = fire[0] | stray[0];
      fsm_done  = fire[1] | stray[1];
      send_done = fire[2] | stray[2];
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    logic [5:0] oseq;
    logic [1:0] last_code;
    bit         post;
    exp_t       e;
    int         nreq;
    oseq = 6'd0; post = 1'b0; last_code = 2'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        oseq = 6'd0;
        post = 1'b0;
      end else begin
        nreq = int'(load_req) + int'(fsm_req) + int'(send_req);
        if (nreq != 0) begin
          check("req_onehot", nreq, 1);
          oseq = {oseq[3:0], load_req ? 2'd1 : fsm_req ? 2'd2 : 2'd3};
        end
        if (post) begin
          check("idle_ready", cmd_ready, 1);
          check("idle_busy", busy, 0);
          check("err_hold", err_code, last_code);
          post = 1'b0;
        end
        if (done) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("err_code", err_code, e.code);
            check("err_phase", err_phase, e.phase);
            check("run_cycles", run_cycles, e.run);
            check("req_sequence", oseq, e.seq);
            check("busy_in_done", busy, 1);
            last_code = e.code;
            post = 1'b1;
          end
          oseq = 6'd0;
        end
      end
    end
  end

  task automatic run_cmd(input logic [2:0] ops, input int d0, input int d1, input int d2,
                         input int ab, input bit sen, input int gap);
    exp_t e;
    int   acc;
    int   g;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    acc = cyc;
    e = model(ops, d0, d1, d2, ab, acc);
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_ops   = ops;
    abort     = 1'b0;
    stray     = 3'b000;
    for (int k = 1; k <= e.done_cyc - acc + 2; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      abort     = (k == ab);
      stray     = sen ? (3'($urandom) & ~ops & 3'($urandom)) : 3'b000;
    end
    abort = 1'b0;
    stray = 3'b000;
    g = 0;
    while ((g < gap || pending()) && g < 100) begin
      @(negedge clk);
      g++;
      stray = sen ? 3'($urandom) & 3'($urandom) : 3'b000;
      abort = sen && ($urandom_range(0, 3) == 0);
    end
    abort = 1'b0;
    stray = 3'b000;
  endtask

  task automatic reset_mid_run();
    dly[0] = NEVER; dly[1] = NEVER; dly[2] = NEVER;
    cmd_valid = 1'b1;
    cmd_ops   = 3'b010;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (k == 5) begin
        check("busy_before_reset", busy, 1);
        rst = 1'b1;
      end
      if (k == 6) begin
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_reqs", {load_req, fsm_req, send_req}, 0);
        check("rst_err_code", err_code, 0);
        check("rst_err_phase", err_phase, 0);
        check("rst_run_cycles", run_cycles, 0);
      end
      if (k == 7) rst = 1'b0;
    end
  endtask

  task automatic dut2_saturate();
    bit seen;
    seen = 1'b0;
    r2_valid = 1'b1;
    r2_ops   = 3'b010;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      r2_valid    = 1'b0;
      r2_fsm_done = (k == 40);
      if (k == 1) check("t0_run_req", r2_fsm_req, 1);
      if (r2_done && !seen) begin
        seen = 1'b1;
        check("t0_done_cycle", k, 41);
        check("t0_err_code", r2_code, 0);
        check("t0_run_sat", r2_run, 7);
      end
    end
    r2_fsm_done = 1'b0;
    check("t0_done_seen", seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t pv;
    logic [2:0] ops;
    int d[3];
    int ab;
    rst = 1'b1; cmd_valid = 1'b0; cmd_ops = 3'b000; abort = 1'b0; stray = 3'b000;
    dly[0] = NEVER; dly[1] = NEVER; dly[2] = NEVER;
    r2_valid = 1'b0; r2_ops = 3'b000; r2_fsm_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_outs", {done, load_req, fsm_req, send_req, err_code, err_phase}, 0);
    check("reset_run_cycles", run_cycles, 0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(3'b111, 5, 5, 5, -1, 1'b0, 2);        // full sequence
    run_cmd(3'b100, 3, 3, 7, -1, 1'b0, 2);        // send only
    run_cmd(3'b000, 1, 1, 1, -1, 1'b0, 2);        // empty command
    run_cmd(3'b000, 1, 1, 1, 1, 1'b0, 2);         // abort in DONE ignored
    run_cmd(3'b010, 1, NEVER, 1, -1, 1'b0, 2);    // run timeout
    run_cmd(3'b010, 1, T, 1, -1, 1'b0, 2);        // done with timeout
    run_cmd(3'b001, 5, 1, 1, 6, 1'b0, 2);         // done with abort
    run_cmd(3'b111, 5, 5, 5, 1, 1'b0, 2);         // abort in LOAD_REQ
    run_cmd(3'b011, 4, 3, 2, -1, 1'b1, 6);        // stray dones
    reset_mid_run();
    run_cmd(3'b111, 2, 3, 4, -1, 1'b0, 2);        // recovery after reset

    for (int i = 0; i < 120; i++) begin
      ops = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++)
        d[p] = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 20);
      pv = model(ops, d[0], d[1], d[2], -1, 0);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, pv.done_cyc) : -1;
      run_cmd(ops, d[0], d[1], d[2], ab, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    dut2_saturate();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
